// File: rtl/mul_share_ctrl.sv
// Two-requester controller sharing one multi-cycle 32x32 multiplier.
// Round-robin grant over valid/ready request channels, operand latching,
// enable/hold sequencing, per-requester response channel and a hold watchdog.
module mul_share_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        single_cycle_i,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [63:0] req_a_i,
  input  logic [63:0] req_b_i,
  input  logic [3:0]  req_signed_i,
  input  logic [1:0]  req_low_i,
  output logic [1:0]  rsp_valid_o,
  output logic [31:0] rsp_result_o,
  output logic        rsp_err_o,
  input  logic [1:0]  rsp_ready_i,
  output logic        mul_enable_o,
  output logic [31:0] mul_first_o,
  output logic [31:0] mul_second_o,
  output logic [1:0]  mul_signed_o,
  output logic        mul_low_o,
  output logic        mul_single_cycle_o,
  input  logic        mul_hold_i,
  input  logic [31:0] mul_result_i,
  output logic        err_sticky_o
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    BUSY = 3'b010,
    DONE = 3'b100
  } state_e;

  // Watchdog fires when the count would reach TIMEOUT-1 with hold still high.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 2);

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic              cur_q, cur_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [1:0]        sgn_q, sgn_d;
  logic              low_q, low_d;
  logic [CNT_W-1:0]  wd_q, wd_d;
  logic [31:0]       res_q, res_d;
  logic              err_q, err_d;
  logic              sticky_q, sticky_d;

  logic              grant;
  logic              gnt_idx;

  // Grant decision: rr pointer breaks ties, otherwise the sole valid requester.
  always_comb begin
    grant   = (state_q == IDLE) && !stall && (|req_valid_i);
    gnt_idx = (&req_valid_i) ? rr_q : req_valid_i[1];
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    cur_d    = cur_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    low_d    = low_q;
    wd_d     = wd_q;
    res_d    = res_q;
    err_d    = err_q;
    sticky_d = sticky_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          cur_d   = gnt_idx;
          rr_d    = ~gnt_idx;
          a_d     = gnt_idx ? req_a_i[63:32] : req_a_i[31:0];
          b_d     = gnt_idx ? req_b_i[63:32] : req_b_i[31:0];
          sgn_d   = gnt_idx ? req_signed_i[3:2] : req_signed_i[1:0];
          low_d   = req_low_i[gnt_idx];
          wd_d    = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!stall) begin
          if (!mul_hold_i) begin
            res_d   = mul_result_i;
            err_d   = 1'b0;
            state_d = DONE;
          end else if (wd_q == WD_LAST) begin
            res_d    = '0;
            err_d    = 1'b1;
            sticky_d = 1'b1;
            state_d  = DONE;
          end else begin
            wd_d = wd_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (rsp_ready_i[cur_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      cur_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= '0;
      low_q    <= 1'b0;
      wd_q     <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cur_q    <= cur_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      low_q    <= low_d;
      wd_q     <= wd_d;
      res_q    <= res_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  // Output decode; ready is gated by reset so it drops as soon as reset asserts.
  always_comb begin
    req_ready_o        = '0;
    if (grant && reset_n) begin
      req_ready_o = gnt_idx ? 2'b10 : 2'b01;
    end
    rsp_valid_o        = '0;
    if (state_q == DONE) begin
      rsp_valid_o = cur_q ? 2'b10 : 2'b01;
    end
    rsp_result_o       = res_q;
    rsp_err_o          = err_q && (state_q == DONE);
    mul_enable_o       = (state_q == BUSY);
    mul_first_o        = a_q;
    mul_second_o       = b_q;
    mul_signed_o       = sgn_q;
    mul_low_o          = low_q;
    mul_single_cycle_o = single_cycle_i;
    err_sticky_o       = sticky_q;
  end

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Two-requester controller that shares the single multi-cycle 32x32 multiplier between requester 0 (integer pipeline) and requester 1 (coprocessor/debug path).
- Arbitrates round-robin over valid/ready request channels and latches the granted operands.
- Sequences the multiplier's enable/hold protocol, then returns the result on a per-requester response channel.
- A watchdog flags a multiplier that never releases hold.

Parameters:
TIMEOUT, 64, max non-stalled BUSY cycles before abort (2..255)
CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
stall  input  1  pipeline stall; freezes sequencing and blocks new grants
single_cycle_i  input  1  quasi-static mode bit, passed to multiplier
req_valid_i  input  2  bit r = request from requester r
req_ready_o  output  2  one-hot grant/accept pulse
req_a_i  input  64  operand A; [32r+31:32r] for requester r
req_b_i  input  64  operand B, same packing
req_signed_i  input  4  signed_mode per requester; [2r+1:2r]
req_low_i  input  2  1 = low word, 0 = high word
rsp_valid_o  output  2  one-hot response valid
rsp_result_o  output  32  result for the requester flagged in rsp_valid_o
rsp_err_o  output  1  response is a watchdog abort; result is 0
rsp_ready_i  input  2  response accept per requester
mul_enable_o  output  1  multiplier enable
mul_first_o  output  32  multiplier first operand
mul_second_o  output  32  multiplier second operand
mul_signed_o  output  2  multiplier signed mode
mul_low_o  output  1  multiplier low/high select
mul_single_cycle_o  output  1  equals single_cycle_i combinationally
mul_hold_i  input  1  multiplier busy
mul_result_i  input  32  multiplier result
err_sticky_o  output  1  set on any watchdog abort; cleared only by reset

Behaviour:
- Reset, asynchronous on reset_n low:
  - FSM to IDLE; rr_ptr=0; all registered outputs 0 (req_ready_o, rsp_*, mul_enable_o, operands, err_sticky_o).
  - A reset mid-operation aborts it; no response is ever issued for it.
- FSM states IDLE, BUSY, DONE. One-hot state encoding.
- IDLE:
  - If stall=0 and any req_valid_i is set, grant one requester.
  - If both are valid, grant rr_ptr's requester. Otherwise grant the sole valid one.
  - The grant cycle drives req_ready_o[g]=1 combinationally (handshake completes in that cycle).
  - Latch operands, signed mode and low bit; set cur=g; rr_ptr<=~g; clear wd_cnt; go to BUSY.
  - If stall=1, no grant: req_ready_o=0.
- BUSY:
  - mul_enable_o=1; latched operands are held stable on mul_* for the whole state.
  - If stall=1: hold state, wd_cnt frozen, mul_hold_i ignored.
  - Else if mul_hold_i=0: capture mul_result_i into the response register; go to DONE next cycle.
  - Else wd_cnt++. When wd_cnt reaches TIMEOUT-1 with hold still high: result register=0, err flag=1, err_sticky_o=1, go to DONE.
  - With single_cycle_i=1 the multiplier drops hold in the first BUSY cycle, so minimum latency from grant is 2 cycles to rsp_valid.
- DONE:
  - mul_enable_o=0; rsp_valid_o[cur]=1; rsp_result_o and rsp_err_o stable.
  - On rsp_ready_i[cur]=1, go to IDLE. A new grant is possible in the next cycle, not the same one.
  - rsp_ready_i of the other requester is ignored. stall does not block response acceptance.
- Outside DONE: rsp_valid_o=0; rsp_result_o holds its last value (don't-care).
- At most one outstanding operation. Requests are never dropped; requesters keep valid high until ready.
- Fairness: under continuous requests from both, grants alternate 0,1,0,1.
- Properties to hold:
  - req_ready_o and rsp_valid_o are each one-hot-or-zero.
  - mul_enable_o=1 iff state=BUSY.
  - mul_* operands do not change while mul_enable_o=1.
  - err_sticky_o is monotonic.

Test Plan:
- Single request: req0 a=7, b=6, low=1, mode unsigned, single_cycle=1 → ready0 pulse at cycle 0; enable at cycle 1; rsp_valid_o=01 with result 42 at cycle 2; rsp_err_o=0.
- Multi-cycle: req1 a=0xFFFFFFFF, b=2, signed 2'b11, low=0; model holds 4 cycles → rsp_valid_o=10, result 0xFFFFFFFF (high word of -2); operands stable throughout.
- Contention: both valid continuously for 4 ops → grant order 0,1,0,1; each response routed to the correct requester.
- Stall: assert stall for 3 cycles mid-BUSY with model hold dropping during stall → completion is deferred until stall=0; no grant occurs in IDLE while stall=1.
- Watchdog: TIMEOUT=8, hold stuck at 1 → at cycle 8 after grant, rsp_valid with result 0, rsp_err_o=1, err_sticky_o=1 until reset.
- Reset mid-BUSY: drop reset_n during hold → all outputs 0 immediately; after release, a new req0 completes normally with rr_ptr=0.
